patch_stream_unit: RTL and testbench
====================================

# patch_stream_unit

Producer side of the `kernel`/`patch`/`buffer_valid` interface consumed by `hadamard_product_unit`. It accepts a raster-order pixel stream, builds 3x3 sliding-window patches with two line buffers, and holds a loaded kernel. Each valid window is presented on `patch`, qualified by a one-cycle `buffer_valid` pulse. It sits between the input memory/DMA stream and the Hadamard/reduction datapath.

## Interface
- `WIDTH`, 32, bits per pixel/kernel element
- `SIZE`, 9, elements per patch (fixed 3x3; any other value is illegal)
- `IMG_W`, 8, image width in pixels (>= 3)
- `IMG_H`, 8, image height in pixels (>= 3)

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `kernel_in`  in  [SIZE-1:0][WIDTH-1:0]  kernel to load
- `kernel_load`  in  1  load strobe for `kernel_in`
- `pixel_in`  in  WIDTH  input pixel
- `in_valid`  in  1  `pixel_in` valid
- `in_ready`  out  1  unit accepts a pixel this cycle
- `kernel`  out  [SIZE-1:0][WIDTH-1:0]  registered kernel to the Hadamard unit
- `patch`  out  [SIZE-1:0][WIDTH-1:0]  registered 3x3 window, row-major
- `buffer_valid`  out  1  one-cycle pulse: `patch`/`kernel` are a new valid pair
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame

## Operation
- States: IDLE, FILL, STREAM, DONE.
- IDLE: `in_ready`=0; `kernel_load`=1 -> register `kernel_in`, go to FILL.
- FILL/STREAM: `in_ready`=1; a pixel is accepted when `in_valid && in_ready`. FILL -> STREAM when the first patch is emitted.
- On the last accepted pixel (row IMG_H-1, col IMG_W-1) -> DONE. Counters wrap to 0.
- DONE: lasts exactly one cycle; `in_ready`=0, `frame_done`=1; `kernel_load` is honoured here (kernel for the next frame); -> FILL. Line buffers are not cleared.
- `kernel_load` in FILL/STREAM is ignored. `kernel` stays stable during a frame.
- Each accept shifts the window left by one column. New column (top..bottom) is {line buffer 2 out, line buffer 1 out, `pixel_in`}.
- Line buffer 1 delays pixels by IMG_W accepts. Line buffer 2 delays line buffer 1's output by IMG_W accepts. Both shift only on accept.
- A patch is emitted for an accepted pixel at (row, col) with row >= 2 and col >= 2. That gives (IMG_H-2)*(IMG_W-2) patches per frame.
- Patch layout: `patch[0]` = (row-2, col-2) through `patch[8]` = (row, col).
- No arithmetic on data. Pixels pass through bit-exact. Counters are `$clog2` of IMG_W/IMG_H.

## Timing
- Reset values: `in_ready`=0, `buffer_valid`=0, `frame_done`=0, `kernel`=0, `patch`=0. State is IDLE; counters, window and line buffers are 0.
- Reset mid-frame discards all partial state; a kernel reload is required afterwards.
- Latency: `buffer_valid` is high the cycle after the accepting edge, for exactly one cycle. `patch` holds until the next emission.
- The downstream has no back-pressure; one patch is possible per accepted pixel.
- `in_valid` while `in_ready`=0: no accept; upstream must hold the pixel.
- The last pixel's `buffer_valid` and `frame_done` are high in the same cycle (DONE).
- Gaps in `in_valid` stall counters and buffers with no state loss.

## Configuration
- `PATCH_STRIDE2_EN` defined: emit only when (row-2) and (col-2) are both even, i.e. stride 2. The window still shifts on every accept.
- `PATCH_STRIDE2_EN` undefined: stride 1, as above.

## Structure
- `conv_pkg` holds:
  - `WIDTH`/`SIZE` defaults and `KDIM`=3
  - state enum `patch_state_t`
  - typedef `patch_t` (`[SIZE-1:0][WIDTH-1:0]`), shared with `hadamard_product_unit`
- One sub-module, `line_buffer`: parameterised depth IMG_W, WIDTH-wide shift register with a shift enable and async reset. It is instantiated twice.

## Test plan
(IMG_W=IMG_H=4 unless noted; pixel = row*4+col+1)
- Reset then `kernel_load` with kernel {1..9} -> `kernel`={1..9} next cycle. In IDLE, `in_ready`=0 before the load and 1 after it.
- Stream 16 pixels back-to-back -> first `buffer_valid` the cycle after pixel 11 is accepted, with `patch`={1,2,3,5,6,7,9,10,11}. Exactly 4 pulses, the last with `patch`={6,7,8,10,11,12,14,15,16}.
- Random `in_valid` gaps -> same 4 patches, `frame_done` once. `in_ready`=0 only in the DONE cycle.
- Second frame with `kernel_load`={9..1} in DONE -> new kernel applies to all patches of frame 2. `kernel_load` mid-frame has no effect.
- Assert `rst` after 7 pixels -> all outputs 0 and `in_ready`=0. After reload, a fresh frame gives the same patches as the first test.
- `PATCH_STRIDE2_EN` with IMG_W=IMG_H=6 -> 4 pulses, for windows at (0,0), (0,2), (2,0), (2,2).

Source files
------------

// File: rtl/patch_stream_unit_pkg.sv
// Shared convolution datapath types: kernel/patch bus shape and the patch
// producer's state encoding.
package conv_pkg;

  localparam int WIDTH = 32;
  localparam int SIZE  = 9;
  localparam int KDIM  = 3;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    DONE
  } patch_state_t;

  typedef logic [SIZE-1:0][WIDTH-1:0] patch_t;

endpackage

// File: rtl/patch_stream_unit_line_buffer.sv
// Row delay line: output is the input from DEPTH shifts ago; holds while
// shift_en_i is low so upstream stalls lose nothing.
module line_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else if (shift_en_i) begin
      mem_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/patch_stream_unit.sv
// 3x3 sliding-window producer: one registered patch per qualifying accept, valid the next cycle;
// no downstream back-pressure, upstream stalled only in IDLE/DONE. Stride 2 with PATCH_STRIDE2_EN.
module patch_stream_unit #(
  parameter int WIDTH = conv_pkg::WIDTH,
  parameter int SIZE  = conv_pkg::SIZE,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SIZE-1:0][WIDTH-1:0]  kernel_in,
  input  logic                        kernel_load,
  input  logic [WIDTH-1:0]            pixel_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [SIZE-1:0][WIDTH-1:0]  kernel,
  output logic [SIZE-1:0][WIDTH-1:0]  patch,
  output logic                        buffer_valid,
  output logic                        frame_done
);

  import conv_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  patch_state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [KDIM-1:0][KDIM-1:0][WIDTH-1:0] win_q, win_d;
  logic [SIZE-1:0][WIDTH-1:0] patch_q, patch_d;
  logic [SIZE-1:0][WIDTH-1:0] kernel_q;
  logic buffer_valid_q, frame_done_q;
  logic kernel_ld;
  logic accept, last_px, emit;
  logic [WIDTH-1:0] lb1_out, lb2_out;

  assign in_ready = (state_q == FILL) || (state_q == STREAM);
  assign accept   = in_valid && in_ready;
  assign last_px  = (col_q == COL_LAST) && (row_q == ROW_LAST);

`ifdef PATCH_STRIDE2_EN
  // (row-2) even is the same as row even, so the LSBs are enough.
  assign emit = accept && (row_q >= RW'(2)) && (col_q >= CW'(2)) && !row_q[0] && !col_q[0];
`else
  assign emit = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
`endif

  line_buffer #(.DEPTH(IMG_W), .WIDTH(WIDTH)) u_lb1 (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (accept),
    .din_i      (pixel_in),
    .dout_o     (lb1_out)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(WIDTH)) u_lb2 (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (accept),
    .din_i      (lb1_out),
    .dout_o     (lb2_out)
  );

  always_comb begin
    state_d   = state_q;
    kernel_ld = 1'b0;
    case (state_q)
      IDLE: begin
        if (kernel_load) begin
          kernel_ld = 1'b1;
          state_d   = FILL;
        end
      end
      FILL: begin
        if (accept && last_px) state_d = DONE;
        else if (emit)         state_d = STREAM;
      end
      STREAM: begin
        if (accept && last_px) state_d = DONE;
      end
      DONE: begin
        kernel_ld = kernel_load;
        state_d   = FILL;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // win_q[row][col]: row 0 is the oldest line, col KDIM-1 the newest column.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < KDIM; r++) begin
        for (int c = 0; c < KDIM - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      win_d[0][KDIM-1] = lb2_out;
      win_d[1][KDIM-1] = lb1_out;
      win_d[2][KDIM-1] = pixel_in;
    end
  end

  always_comb begin
    patch_d = '0;
    for (int r = 0; r < KDIM; r++) begin
      for (int c = 0; c < KDIM; c++) begin
        patch_d[r*KDIM+c] = win_d[r][c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      col_q          <= '0;
      row_q          <= '0;
      win_q          <= '0;
      patch_q        <= '0;
      kernel_q       <= '0;
      buffer_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      win_q          <= win_d;
      buffer_valid_q <= emit;
      frame_done_q   <= accept && last_px;
      if (kernel_ld) kernel_q <= kernel_in;
      if (emit)      patch_q  <= patch_d;
    end
  end

  assign kernel       = kernel_q;
  assign patch        = patch_q;
  assign buffer_valid = buffer_valid_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_patch_stream_unit.sv
// Directed bench for patch_stream_unit; expected patches come from pixel = row*IMG+col+1.
`timescale 1ns/1ps
module tb_patch_stream_unit;
  import conv_pkg::*;

`ifdef PATCH_STRIDE2_EN
  localparam int IMG = 6;
`else
  localparam int IMG = 4;
`endif
  localparam int EXP_PULSES = 4;

  logic             clk;
  logic             rst;
  patch_t           kernel_in;
  logic             kernel_load;
  logic [WIDTH-1:0] pixel_in;
  logic             in_valid;
  logic             in_ready;
  patch_t           kernel;
  patch_t           patch;
  logic             buffer_valid;
  logic             frame_done;

  int errors;
  int checks;
  int pulses;
  int dones;

  patch_t kinc, kdec, kjunk;

  patch_stream_unit #(.WIDTH(WIDTH), .SIZE(SIZE), .IMG_W(IMG), .IMG_H(IMG)) dut (
    .clk          (clk),
    .rst          (rst),
    .kernel_in    (kernel_in),
    .kernel_load  (kernel_load),
    .pixel_in     (pixel_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .kernel       (kernel),
    .patch        (patch),
    .buffer_valid (buffer_valid),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (buffer_valid) pulses++;
    if (frame_done)   dones++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [SIZE*WIDTH-1:0] got,
                       input logic [SIZE*WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic patch_t exp_patch(input int r, input int c);
    patch_t p;
    for (int i = 0; i < KDIM; i++)
      for (int j = 0; j < KDIM; j++)
        p[i*KDIM+j] = WIDTH'((r - 2 + i) * IMG + (c - 2 + j) + 1);
    return p;
  endfunction

  function automatic bit emit_exp(input int r, input int c);
`ifdef PATCH_STRIDE2_EN
    return (r >= 2) && (c >= 2) && (r % 2 == 0) && (c % 2 == 0);
`else
    return (r >= 2) && (c >= 2);
`endif
  endfunction

  // Returns at the negedge following the accepting edge.
  task automatic send_px(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    pixel_in = v;
    in_valid = 1'b1;
    while (!in_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input bit gaps, input patch_t kexp, input bit mid_load);
    int p0, d0;
    bit last;
    #1;
    p0 = pulses;
    d0 = dones;
    for (int r = 0; r < IMG; r++) begin
      for (int c = 0; c < IMG; c++) begin
        send_px(WIDTH'(r * IMG + c + 1));
        last = (r == IMG - 1) && (c == IMG - 1);
        check("bv", buffer_valid, emit_exp(r, c));
        if (emit_exp(r, c)) begin
          check("patch", patch, exp_patch(r, c));
          check("kernel", kernel, kexp);
        end
        check("frame_done", frame_done, last);
        if (last) begin
          check("rdy_done", in_ready, 0);
        end else if (gaps) begin
          repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check("rdy_gap", in_ready, 1);
            check("bv_gap", buffer_valid, 0);
          end
        end
        if (mid_load && r == 1 && c == 1) begin
          kernel_in   = kjunk;
          kernel_load = 1'b1;
          @(negedge clk);
          kernel_load = 1'b0;
          check("kern_mid", kernel, kexp);
        end
      end
    end
    #1;
    check("pulse_count", pulses - p0, EXP_PULSES);
    check("done_count", dones - d0, 1);
  endtask

  initial begin
    errors = 0; checks = 0; pulses = 0; dones = 0;
    for (int i = 0; i < SIZE; i++) begin
      kinc[i]  = WIDTH'(i + 1);
      kdec[i]  = WIDTH'(SIZE - i);
      kjunk[i] = WIDTH'(32'hA5A5_0000 + i);
    end
    rst = 1'b1; in_valid = 1'b0; kernel_load = 1'b0; pixel_in = '0; kernel_in = '0;
    repeat (2) @(negedge clk);
    check("rst_rdy", in_ready, 0);
    check("rst_bv", buffer_valid, 0);
    check("rst_fd", frame_done, 0);
    check("rst_kernel", kernel, 0);
    check("rst_patch", patch, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_rdy", in_ready, 0);
    kernel_in = kinc;
    kernel_load = 1'b1;
    @(negedge clk);
    kernel_load = 1'b0;
    check("kload", kernel, kinc);
    check("fill_rdy", in_ready, 1);

    run_frame(1'b0, kinc, 1'b0);

    kernel_in = kdec;
    kernel_load = 1'b1;
    @(negedge clk);
    kernel_load = 1'b0;
    check("k2", kernel, kdec);
    check("rdy_after_done", in_ready, 1);

    run_frame(1'b1, kdec, 1'b1);

    @(negedge clk);
    check("k_keep", kernel, kdec);
    for (int i = 0; i < 7; i++) send_px(WIDTH'(i + 1));
    rst = 1'b1;
    #1;
    check("mid_rst_rdy", in_ready, 0);
    check("mid_rst_bv", buffer_valid, 0);
    check("mid_rst_fd", frame_done, 0);
    check("mid_rst_kernel", kernel, 0);
    check("mid_rst_patch", patch, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    pixel_in = WIDTH'(99);
    repeat (2) begin
      @(negedge clk);
      check("post_rst_rdy", in_ready, 0);
    end
    in_valid = 1'b0;
    kernel_in = kinc;
    kernel_load = 1'b1;
    @(negedge clk);
    kernel_load = 1'b0;
    check("reload", kernel, kinc);

    run_frame(1'b1, kinc, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
